// File: rtl/pwm_deadtime_gen_if.sv
// Bus bundle between the PWM source and the dead-time generator.
// The master drives the PWM level, enable and dead-time programming;
// the slave returns the gate drives and status flags.
interface pwm_deadtime_gen_if #(
    parameter int DT_WIDTH = 8
);
    logic                pwm_in;
    logic                enable;
    logic [DT_WIDTH-1:0] dt_in;
    logic                dt_wr;
    logic                hs_out;
    logic                ls_out;
    logic                busy;
    logic                fault;

    modport master (
        output pwm_in, enable, dt_in, dt_wr,
        input  hs_out, ls_out, busy, fault
    );

    modport slave (
        input  pwm_in, enable, dt_in, dt_wr,
        output hs_out, ls_out, busy, fault
    );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Half-bridge dead-time generator.
// Turns a single-ended PWM into complementary high-side/low-side gate drives,
// with a programmable all-low gap on every transition. Short pulses that end
// inside the gap are swallowed and the bridge returns to its previous side.
module pwm_deadtime_gen #(
    parameter int DT_WIDTH   = 8,
    parameter int DEFAULT_DT = 4
) (
    input logic               clk,
    input logic               rst_n,
    pwm_deadtime_gen_if.slave bus
);

    typedef enum logic [2:0] {
        OFF,
        DT_FALL,
        LS_ON,
        DT_RISE,
        HS_ON
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DT_WIDTH-1:0] dt_reg;
    logic [DT_WIDTH-1:0] cnt;
    logic [DT_WIDTH-1:0] cnt_nxt;
    logic [DT_WIDTH-1:0] cnt_dec;
    logic                cnt_done;
    logic                dt_zero;
    logic                pwm_q;
    logic                from_hs;
    logic                from_hs_nxt;
    logic                hs_d;
    logic                ls_d;
    logic                busy_d;
    logic                fault_set;
    logic                hs_r;
    logic                ls_r;
    logic                busy_r;
    logic                fault_r;

    // Counter steps down but sticks at zero so a huge dead time never wraps.
    assign cnt_dec  = (cnt == '0) ? '0 : cnt - DT_WIDTH'(1);
    assign cnt_done = (cnt <= DT_WIDTH'(1));
    assign dt_zero  = (dt_reg == '0);

    // Input synchroniser stage and dead-time register; a new value only
    // affects intervals that start after it is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q  <= 1'b0;
            dt_reg <= DT_WIDTH'(DEFAULT_DT);
        end else begin
            pwm_q <= bus.pwm_in;
            if (bus.dt_wr) begin
                dt_reg <= bus.dt_in;
            end
        end
    end

    // State register plus registered gate drives decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OFF;
            cnt     <= '0;
            from_hs <= 1'b0;
            hs_r    <= 1'b0;
            ls_r    <= 1'b0;
            busy_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            from_hs <= from_hs_nxt;
            fault_r <= fault_r | fault_set;
            hs_r    <= hs_d & ~fault_set & ~fault_r;
            ls_r    <= ls_d & ~fault_set & ~fault_r;
            busy_r  <= busy_d;
        end
    end

    // Next-state logic; an expiring gap takes priority over an abort.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        from_hs_nxt = from_hs;
        if (!bus.enable) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_nxt   = DT_FALL;
                    cnt_nxt     = dt_reg;
                    from_hs_nxt = 1'b0;
                end
                DT_FALL: begin
                    cnt_nxt = cnt_dec;
                    if (cnt_done) begin
                        state_nxt = LS_ON;
                    end else if (pwm_q && from_hs) begin
                        state_nxt = HS_ON;
                        cnt_nxt   = '0;
                    end
                end
                LS_ON: begin
                    if (pwm_q) begin
                        if (dt_zero) begin
                            state_nxt = HS_ON;
                        end else begin
                            state_nxt = DT_RISE;
                            cnt_nxt   = dt_reg;
                        end
                    end
                end
                DT_RISE: begin
                    cnt_nxt = cnt_dec;
                    if (cnt_done) begin
                        state_nxt = HS_ON;
                    end else if (!pwm_q) begin
                        state_nxt = LS_ON;
                        cnt_nxt   = '0;
                    end
                end
                HS_ON: begin
                    if (!pwm_q) begin
                        if (dt_zero) begin
                            state_nxt = LS_ON;
                        end else begin
                            state_nxt   = DT_FALL;
                            cnt_nxt     = dt_reg;
                            from_hs_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode of the upcoming state; both-high is treated as a fault.
    always_comb begin
        hs_d      = (state_nxt == HS_ON);
        ls_d      = (state_nxt == LS_ON);
        busy_d    = (state_nxt == DT_FALL) || (state_nxt == DT_RISE);
        fault_set = hs_d & ls_d;
    end

    assign bus.hs_out = hs_r;
    assign bus.ls_out = ls_r;
    assign bus.busy   = busy_r;
    assign bus.fault  = fault_r;

    // Shoot-through must never be driven and the fault flag must never set.
    a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n) !(hs_r && ls_r));
    a_no_fault   : assert property (@(posedge clk) disable iff (!rst_n) !fault_set);

endmodule
